fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer/flag controller that turns a depth-2**ADDR_WIDTH register file into a FIFO for the DSP sample path.
- Accepts push/pop requests from producer and consumer. Generates the write address, write enable, read address and read enable for the register file.
- The register file has a synchronous write port and a registered, enable-gated read port. This block drives that read enable and reports when the registered read data is valid.

Parameters:
- ADDR_WIDTH, 2, register-file address width; FIFO depth DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- wr  input  1  producer push request (data presented to register file w_data same cycle)
- rd  input  1  consumer pop request
- w_en  output  1  register-file write enable (accepted push)
- w_addr  output  ADDR_WIDTH  register-file write address (write pointer)
- r_en  output  1  register-file read enable (accepted pop)
- r_addr  output  ADDR_WIDTH  register-file read address (read pointer)
- rd_valid  output  1  register-file r_data holds popped word this cycle
- full  output  1  FIFO holds DEPTH words
- empty  output  1  FIFO holds 0 words
- ovf  output  1  one-cycle pulse: push rejected
- udf  output  1  one-cycle pulse: pop rejected

Behaviour:
- State: wptr, rptr, each ADDR_WIDTH+1 bits (MSB = wrap bit). w_addr = wptr[ADDR_WIDTH-1:0]; r_addr = rptr[ADDR_WIDTH-1:0].
- Flags, combinational from pointers:
  - empty = (wptr == rptr).
  - full = low bits equal and wrap bits differ.
- Accept rules, combinational:
  - r_en = rd & ~empty.
  - w_en = wr & (~full | rd).
  - Full + wr + rd: both accepted. w_addr == r_addr in that cycle; the register file returns the old word because its read is registered.
  - Empty + wr + rd: write accepted, read rejected (no fall-through). udf pulses.
- Pointer update on posedge clk: wptr += w_en; rptr += r_en. Arithmetic is modulo 2**(ADDR_WIDTH+1), so wrap is natural and DEPTH-1 -> 0 needs no special case.
- rd_valid: registered copy of r_en. Read latency is 1 cycle, and rd_valid aligns with the register file's registered r_data.
- Error pulses, registered, high for exactly one cycle:
  - ovf = wr & full & ~rd.
  - udf = rd & empty.
  - Pulses repeat every cycle the condition holds.
- Reset, asynchronous, effective immediately: wptr = 0, rptr = 0, rd_valid = 0, ovf = 0, udf = 0. Result is empty = 1, full = 0, w_en/r_en driven by inputs under the empty rules.
- Reset mid-operation:
  - Contents are discarded logically; register-file storage is not cleared.
  - A pending rd_valid is dropped.
  - First push after release of reset goes to address 0.
- No other state; no FSM beyond the pointers. Occupancy is never negative and never exceeds DEPTH.

Optional Feature:
- Macro: FIFO_CTRL_COUNT_EN.
- Defined:
  - Adds output count [ADDR_WIDTH:0] = wptr - rptr (0..DEPTH), combinational, 0 during reset.
  - Adds output almost_full = (count >= DEPTH-1).
- Undefined: neither port exists. All other behaviour is identical.

Test Plan:
- ADDR_WIDTH=2, reset pulse mid-cycle with no clk edge -> empty=1, full=0, rd_valid=0, w_addr=0, r_addr=0 immediately.
- Push 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> w_addr 0,1,2,3; full=1 after 4th edge. 5th push alone -> w_en=0, ovf pulses 1 cycle, pointers unchanged.
- From full, pop 4 times -> r_addr 0,1,2,3; rd_valid high the cycle after each r_en; r_data 0x11,0x22,0x33,0x44; empty=1 after 4th edge. Extra pop -> r_en=0, udf pulse.
- Full and wr=rd=1 for 3 cycles -> each cycle w_en=r_en=1, full stays 1, read returns the old word at the shared address. Sequence continues 0x11,0x22,0x33.
- Empty and wr=rd=1 -> w_en=1, r_en=0, udf=1 next cycle, empty=0 after edge. Then 6 push/pop pairs -> pointers wrap past 3 to 0, data order preserved.
- With FIFO_CTRL_COUNT_EN: 3 pushes -> count=3, almost_full=1; assert reset -> count=0, almost_full=0 asynchronously.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that runs a 2**ADDR_WIDTH register file as a FIFO.
// Define FIFO_CTRL_COUNT_EN to add the count and almost_full outputs.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
`ifdef FIFO_CTRL_COUNT_EN
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
`endif
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;

  assign w_addr = wptr[ADDR_WIDTH-1:0];
  assign r_addr = rptr[ADDR_WIDTH-1:0];

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                 (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  // A push into a full FIFO is fine when a pop frees the slot in the same
  // cycle; the registered read returns the old word before it is overwritten.
  assign r_en = rd & ~empty;
  assign w_en = wr & (~full | rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      wptr     <= wptr + {{ADDR_WIDTH{1'b0}}, w_en};
      rptr     <= rptr + {{ADDR_WIDTH{1'b0}}, r_en};
      rd_valid <= r_en;
      ovf      <= wr & full & ~rd;
      udf      <= rd & empty;
    end
  end

`ifdef FIFO_CTRL_COUNT_EN
  assign count       = wptr - rptr;
  assign almost_full = (count >= (ADDR_WIDTH + 1)'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed table-driven bench for fifo_ctrl (ADDR_WIDTH=2) with a small
// register-file model so popped data order can be checked.
module tb_fifo_ctrl;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr, rd;
  logic          w_en, r_en, rd_valid, full, empty, ovf, udf;
  logic [AW-1:0] w_addr, r_addr;
`ifdef FIFO_CTRL_COUNT_EN
  logic [AW:0]   count;
  logic          almost_full;
`endif

  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] mem [4];

  int n_cmp = 0;
  int n_err = 0;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_en(w_en), .w_addr(w_addr), .r_en(r_en), .r_addr(r_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
`ifdef FIFO_CTRL_COUNT_EN
    .count(count), .almost_full(almost_full),
`endif
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, registered enable-gated read.
  always @(posedge clk) begin
    if (r_en) r_data <= mem[r_addr];
    if (w_en) mem[w_addr] <= w_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       wr, rd;
    logic [7:0] wd;
    logic       w_en, r_en;
    logic [1:0] wa, ra;
    logic       full, empty;
    logic       rdv, ovf, udf;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr_i, rd_i, input logic [7:0] wd,
                     input logic we, re, input logic [1:0] wa, ra,
                     input logic f, e, rdv, o, u, input logic [7:0] rdat);
    vec_t v;
    v.wr = wr_i; v.rd = rd_i; v.wd = wd; v.w_en = we; v.r_en = re;
    v.wa = wa; v.ra = ra; v.full = f; v.empty = e;
    v.rdv = rdv; v.ovf = o; v.udf = u; v.rdata = rdat;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    wr = v.wr; rd = v.rd; w_data = v.wd;
    #1;
    check($sformatf("v%0d w_en", idx), 32'(w_en), 32'(v.w_en));
    check($sformatf("v%0d r_en", idx), 32'(r_en), 32'(v.r_en));
    check($sformatf("v%0d w_addr", idx), 32'(w_addr), 32'(v.wa));
    check($sformatf("v%0d r_addr", idx), 32'(r_addr), 32'(v.ra));
    check($sformatf("v%0d full", idx), 32'(full), 32'(v.full));
    check($sformatf("v%0d empty", idx), 32'(empty), 32'(v.empty));
    @(posedge clk);
    #1;
    check($sformatf("v%0d rd_valid", idx), 32'(rd_valid), 32'(v.rdv));
    check($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.ovf));
    check($sformatf("v%0d udf", idx), 32'(udf), 32'(v.udf));
    if (v.rdv) check($sformatf("v%0d r_data", idx), 32'(r_data), 32'(v.rdata));
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    #3;
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst udf", 32'(udf), 32'd0);
    check("rst w_addr", 32'(w_addr), 32'd0);
    check("rst r_addr", 32'(r_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //   wr rd wd      we re wa ra f e  rdv o u rdata
    add(1, 0, 8'h11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h22, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h33, 1, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h44, 1, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h55, 0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00); // overflow
    add(1, 0, 8'h55, 0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00); // overflow repeats
    add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'h11);
    add(0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 8'h22);
    add(0, 1, 8'h00, 0, 1, 0, 2, 0, 0, 1, 0, 0, 8'h33);
    add(0, 1, 8'h00, 0, 1, 0, 3, 0, 0, 1, 0, 0, 8'h44);
    add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00); // underflow
    add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00); // underflow repeats
    add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    // refill, then push+pop while full
    add(1, 0, 8'h11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h22, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h33, 1, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 8'h44, 1, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 1, 8'h55, 1, 1, 0, 0, 1, 0, 1, 0, 0, 8'h11);
    add(1, 1, 8'h66, 1, 1, 1, 1, 1, 0, 1, 0, 0, 8'h22);
    add(1, 1, 8'h77, 1, 1, 2, 2, 1, 0, 1, 0, 0, 8'h33);
    add(0, 1, 8'h00, 0, 1, 3, 3, 1, 0, 1, 0, 0, 8'h44);
    add(0, 1, 8'h00, 0, 1, 3, 0, 0, 0, 1, 0, 0, 8'h55);
    add(0, 1, 8'h00, 0, 1, 3, 1, 0, 0, 1, 0, 0, 8'h66);
    add(0, 1, 8'h00, 0, 1, 3, 2, 0, 0, 1, 0, 0, 8'h77);
    // push+pop while empty: write only, no fall-through
    add(1, 1, 8'h88, 1, 0, 3, 3, 0, 1, 0, 0, 1, 8'h00);
    add(1, 1, 8'h91, 1, 1, 0, 3, 0, 0, 1, 0, 0, 8'h88);
    add(1, 1, 8'h92, 1, 1, 1, 0, 0, 0, 1, 0, 0, 8'h91);
    add(1, 1, 8'h93, 1, 1, 2, 1, 0, 0, 1, 0, 0, 8'h92);
    add(1, 1, 8'h94, 1, 1, 3, 2, 0, 0, 1, 0, 0, 8'h93);
    add(1, 1, 8'h95, 1, 1, 0, 3, 0, 0, 1, 0, 0, 8'h94);
    add(1, 1, 8'h96, 1, 1, 1, 0, 0, 0, 1, 0, 0, 8'h95);
    add(0, 1, 8'h00, 0, 1, 2, 1, 0, 0, 1, 0, 0, 8'h96);
    add(0, 0, 8'h00, 0, 0, 2, 2, 0, 1, 0, 0, 0, 8'h00);
    // lead-in for the mid-operation reset
    add(1, 0, 8'hAA, 1, 0, 2, 2, 0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'hBB, 1, 0, 3, 2, 0, 0, 0, 0, 0, 8'h00);
    add(0, 1, 8'h00, 0, 1, 0, 2, 0, 0, 1, 0, 0, 8'hAA);

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset between edges drops rd_valid and both pointers.
    wr = 1'b0; rd = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid rst rd_valid", 32'(rd_valid), 32'd0);
    check("mid rst empty", 32'(empty), 32'd1);
    check("mid rst full", 32'(full), 32'd0);
    check("mid rst r_addr", 32'(r_addr), 32'd0);
    check("mid rst w_addr", 32'(w_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr = 1'b1; w_data = 8'hCC;
    #1;
    check("post rst w_addr", 32'(w_addr), 32'd0);
    check("post rst w_en", 32'(w_en), 32'd1);
    @(negedge clk);
    wr = 1'b0; rd = 1'b1;
    #1;
    check("post rst r_addr", 32'(r_addr), 32'd0);
    @(posedge clk);
    #1;
    check("post rst rd_valid", 32'(rd_valid), 32'd1);
    check("post rst r_data", 32'(r_data), 32'hCC);
    @(negedge clk);
    rd = 1'b0;

`ifdef FIFO_CTRL_COUNT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr = 1'b1; w_data = 8'(i);
    end
    @(negedge clk);
    wr = 1'b0;
    #1;
    check("count 3", 32'(count), 32'd3);
    check("almost_full 3", 32'(almost_full), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("count rst", 32'(count), 32'd0);
    check("almost_full rst", 32'(almost_full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
